// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the RV32M multi-cycle sequencer: funct3 op codes, FSM states
// and small op-classification helpers.
package muldiv_sequencer_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_rs1_signed(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    function automatic logic f3_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage handshake between the pipeline (master) and the mul/div sequencer (slave).
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, rs1, rs2,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, flush, funct3, rs1, rs2,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring trial
// subtract for divide. Purely combinational; the top registers acc/lo.
module muldiv_sequencer_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] rem_sub;
    logic            ge;

    always_comb begin
        // Multiply: {acc,lo} shifts right, carry of the add enters acc MSB.
        sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: remainder shifts left taking the next dividend bit from lo.
        shifted = {acc_i, lo_i[XLEN-1]};
        ge      = (shifted >= {1'b0, opnd_i});
        rem_sub = shifted[XLEN-1:0] - opnd_i;

        if (is_div_i) begin
            acc_o = ge ? rem_sub : shifted[XLEN-1:0];
            lo_o  = {lo_i[XLEN-2:0], ge};
        end else begin
            acc_o = sum[XLEN:1];
            lo_o  = {sum[0], lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle mul/div controller: IDLE -> CALC (XLEN steps) -> FIX -> DONE.
// Optional MULDIV_EARLY_OUT_EN finishes zero-operand ops straight from IDLE.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              dbz_q, dbz_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   step_acc, step_lo;
    logic              accept, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2, fix_res;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic              early_out;
    logic [XLEN-1:0]   early_res;

    assign accept = (state_q == ST_IDLE) && bus.start && !bus.flush;
    assign neg1   = f3_rs1_signed(bus.funct3) && bus.rs1[XLEN-1];
    assign neg2   = f3_rs2_signed(bus.funct3) && bus.rs2[XLEN-1];
    assign mag1   = neg1 ? -bus.rs1 : bus.rs1;
    assign mag2   = neg2 ? -bus.rs2 : bus.rs2;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = f3_is_div(bus.funct3) ? (bus.rs2 == '0)
                                             : ((bus.rs1 == '0) || (bus.rs2 == '0));
    assign early_res = !f3_is_div(bus.funct3) ? '0 : (bus.funct3[1] ? bus.rs1 : '1);
`else
    assign early_out = 1'b0;
    assign early_res = '0;
`endif

    muldiv_sequencer_step #(.XLEN(XLEN)) u_step (
        .is_div_i (f3_is_div(f3_q)),
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .lo_o     (step_lo)
    );

    // Operands were iterated as magnitudes; restore signs and pick the requested half.
    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = neg_lo_q ? -prod : prod;
        case (f3_q)
            F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = dbz_q ? '1 : (neg_lo_q ? -lo_q : lo_q);
            default:                      fix_res = neg_rem_q ? -acc_q : acc_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        neg_lo_d  = neg_lo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f3_d      = bus.funct3;
                    cnt_d     = CNT_W'(XLEN);
                    acc_d     = '0;
                    neg_lo_d  = neg1 ^ neg2;
                    neg_rem_d = neg1;
                    dbz_d     = (bus.rs2 == '0);
                    if (f3_is_div(bus.funct3)) begin
                        lo_d   = mag1;
                        opnd_d = mag2;
                    end else begin
                        lo_d   = mag2;
                        opnd_d = mag1;
                    end
                    if (early_out) begin
                        state_d  = ST_DONE;
                        result_d = early_res;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                result_d = fix_res;
                state_d  = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            f3_q      <= '0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            acc_q     <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            neg_lo_q  <= neg_lo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE) && !bus.flush;
    assign bus.stall  = (bus.start || bus.busy) && !bus.done;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + scoreboard bench for muldiv_sequencer (honours MULDIV_EARLY_OUT_EN latency).
module tb_muldiv_sequencer;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] sbq[$];
    logic [31:0] last_res = '0;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sbv, ub;
        logic [63:0] p;
        int q;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ub  = longint'({32'b0, b});
        case (f3)
            MUL:    begin p = 64'(sa * sbv); return p[31:0];  end
            MULH:   begin p = 64'(sa * sbv); return p[63:32]; end
            MULHSU: begin p = 64'(sa * ub);  return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        int l;
        l = 34;
`ifdef MULDIV_EARLY_OUT_EN
        if (f3[2] ? (b == 0) : (a == 0 || b == 0)) l = 1;
`endif
        return l;
    endfunction

    // Waits (bounded) for done, sampling on falling edges after the accepting edge.
    task automatic wait_done(output int lat, output bit seen, output bit stall_ok);
        lat = 0; seen = 0; stall_ok = 1;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) seen = 1;
            else if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_ok = 0;
        end
    endtask

    task automatic finish_op(input string tag, input int lat, input bit seen,
                             input bit stall_ok, input int elat);
        logic [31:0] exp_r;
        exp_r = sbq.pop_front();
        check(32'(seen), 32'd1, $sformatf("%s.done_seen", tag));
        check(32'(lat), 32'(elat), $sformatf("%s.latency", tag));
        check(32'(stall_ok), 32'd1, $sformatf("%s.stall_busy", tag));
        check(bus.result, exp_r, $sformatf("%s.result", tag));
        @(negedge clk);
        check(32'(bus.done), 32'd0, $sformatf("%s.done_pulse", tag));
        check(32'(bus.busy), 32'd0, $sformatf("%s.idle_after", tag));
        check(bus.result, exp_r, $sformatf("%s.result_held", tag));
        last_res = exp_r;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input string tag);
        int lat; bit seen; bit stall_ok;
        sbq.push_back(exp_res);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b;
        #1 check(32'(bus.stall), 32'd1, $sformatf("%s.stall_req", tag));
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.rs1 = $urandom; bus.rs2 = $urandom; bus.funct3 = 3'($urandom);
        wait_done(lat, seen, stall_ok);
        finish_op(tag, lat, seen, stall_ok, exp_latency(f3, a, b));
    endtask

    initial begin
        int lat; bit seen; bit stall_ok; int dcount;
        logic [2:0] f3; logic [31:0] a, b;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;

        repeat (3) @(negedge clk);
        check(32'(bus.busy), 32'd0, "rst.busy");
        check(32'(bus.done), 32'd0, "rst.done");
        check(32'(bus.stall), 32'd0, "rst.stall");
        check(bus.result, 32'd0, "rst.result");
        rst_n = 1'b1;

        run_op(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_-7/2");
        run_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_-7/2");
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
        run_op(DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
        run_op(REMU,   32'd5,         32'd0,         32'd5,         "remu_by0");
        run_op(DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_neg_by0");
        run_op(MUL,    32'd0,         32'h1234_5678, 32'd0,         "mul_zero");

        for (int i = 0; i < 8; i++) begin
            f3 = 3'(i);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            run_op(f3, a, b, model(f3, a, b), $sformatf("rnd%0d", i));
        end

        // Flush during CALC: op dies, previous result stays visible.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MUL; bus.rs1 = 32'd11; bus.rs2 = 32'd13;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check(32'(bus.busy), 32'd0, "flush.busy");
        check(bus.result, last_res, "flush.result_now");
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
        end
        check(32'(dcount), 32'd0, "flush.no_done");
        check(bus.result, last_res, "flush.result_later");
        run_op(MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, "after_flush");

        // Start and flush together: not accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd3;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
        @(negedge clk);
        check(32'(bus.busy), 32'd0, "start_flush.busy");

        // Start held through the op, operands changing: only one op, sampled at accept.
        sbq.push_back(32'd14);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
        @(posedge clk);
        #1 begin bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'd0; bus.funct3 = MUL; end
        wait_done(lat, seen, stall_ok);
        bus.start = 1'b0;
        finish_op("held", lat, seen, stall_ok, 34);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
        end
        check(32'(dcount), 32'd0, "held.single_op");

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MUL; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(32'(bus.busy), 32'd0, "midrst.busy");
        check(32'(bus.done), 32'd0, "midrst.done");
        check(32'(bus.stall), 32'd0, "midrst.stall");
        check(bus.result, 32'd0, "midrst.result");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(REMU, 32'd100, 32'd7, 32'd2, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
